la_vskid: RTL and testbench

N-bit vectorized two-entry elastic register slice (skid buffer) with valid/ready handshake on both sides. It is the registered stage directly upstream of the vectorized buffer cell: its `out_data` drives the buffer's `a` input, breaking long combinational valid/ready/data paths before a wide buffered fan-out. It sustains full throughput with registered outputs and no combinational path from input to output.

---
 rtl/la_vskid_pkg.sv | 13 +
 rtl/la_vskid_reg.sv | 37 +++
 rtl/la_vskid.sv | 114 +++++++++++
 tb/tb_la_vskid.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/la_vskid_pkg.sv
// Shared types for the la_vskid elastic register slice.
// Optional build macro LA_VSKID_ZERO_EN is consumed by la_vskid.sv.
package la_vskid_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } state_e;

endpackage

// File: rtl/la_vskid_reg.sv
// N-bit storage register with load enable and synchronous active-low clear.
// PROP names the custom cell flavour; the generic model maps every flavour to plain flops.
module la_vskid_reg #(
    parameter int unsigned N    = 1,
    parameter string       PROP = "DEFAULT"
) (
    input  logic         clk_i,
    input  logic         clr_ni,
    input  logic         en_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] q_q;

    if (PROP == "DEFAULT") begin : g_generic
        always_ff @(posedge clk_i) begin
            if (!clr_ni) begin
                q_q <= '0;
            end else if (en_i) begin
                q_q <= d_i;
            end
        end
    end else begin : g_prop
        // Library-specific cell flavours share the generic flop behaviour.
        always_ff @(posedge clk_i) begin
            if (!clr_ni) begin
                q_q <= '0;
            end else if (en_i) begin
                q_q <= d_i;
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/la_vskid.sv
// Two-entry valid/ready skid buffer with fully registered outputs.
// Define LA_VSKID_ZERO_EN to force out_data to zero whenever out_valid is low.
module la_vskid
    import la_vskid_pkg::*;
#(
    parameter int unsigned N    = 1,
    parameter string       PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    state_e       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         in_fire, out_fire;
    logic         main_en, skid_en, main_clr_n;
    logic [N-1:0] main_d, main_q, skid_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        main_en = 1'b1;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        skid_en = 1'b1;
                        state_d = StFull;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_fire) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
    end

`ifdef LA_VSKID_ZERO_EN
    // Clear main on every transition into empty so the fan-out stays quiet.
    assign main_clr_n = nreset & (state_d != StEmpty);
`else
    assign main_clr_n = nreset;
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    la_vskid_reg #(
        .N    (N),
        .PROP (PROP)
    ) u_main (
        .clk_i  (clk),
        .clr_ni (main_clr_n),
        .en_i   (main_en),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    la_vskid_reg #(
        .N    (N),
        .PROP (PROP)
    ) u_skid (
        .clk_i  (clk),
        .clr_ni (nreset),
        .en_i   (skid_en),
        .d_i    (in_data),
        .q_o    (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

endmodule

// File: tb/tb_la_vskid.sv
// Randomized and directed bench for la_vskid against a two-slot FIFO reference model.
module tb_la_vskid;

    logic       clk = 1'b0;
    logic       nreset, flush, in_valid, out_ready;
    logic       in_ready, out_valid;
    logic [7:0] in_data, out_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: an ordered list of accepted words, capacity two.
    logic [7:0] mq[$];
    logic       m_rdy;
    logic [7:0] m_last;

`ifdef LA_VSKID_ZERO_EN
    localparam bit ZeroEn = 1'b1;
`else
    localparam bit ZeroEn = 1'b0;
`endif

    la_vskid #(
        .N    (8),
        .PROP ("DEFAULT")
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit inf, outf;
        if (!nreset) begin
            mq.delete();
            m_rdy  = 1'b0;
            m_last = 8'h00;
        end else if (flush) begin
            mq.delete();
            m_rdy = 1'b1;
            if (ZeroEn) m_last = 8'h00;
        end else begin
            inf  = in_valid && m_rdy;
            outf = out_ready && (mq.size() > 0);
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(in_data);
            m_rdy = (mq.size() < 2);
            if (mq.size() > 0) m_last = mq[0];
            else if (ZeroEn) m_last = 8'h00;
        end
    endtask

    // One clock: advance model at the edge, compare all outputs 1ns later.
    task automatic cycle();
        logic [7:0] exp_data;
        @(posedge clk);
        model_edge();
        #1;
        exp_data = (mq.size() > 0) ? mq[0] : m_last;
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("in_ready", 32'(in_ready), 32'(m_rdy));
        check("out_data", 32'(out_data), 32'(exp_data));
    endtask

    initial begin
        nreset    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b0;
        m_rdy     = 1'b0;
        m_last    = 8'h00;

        // Reset held for three edges with a word offered.
        repeat (3) cycle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        nreset   = 1'b1;
        in_valid = 1'b0;
        cycle();
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            cycle();
            check("stream_data", 32'(out_data), 32'(i));
            check("stream_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        cycle();

        // Back-pressure: 0x21 lands in skid, 0x22 waits upstream.
        in_valid = 1'b1;
        in_data  = 8'h20;
        cycle();
        check("bp_show20", 32'(out_data), 32'h20);
        out_ready = 1'b0;
        in_data   = 8'h21;
        cycle();
        check("bp_full_rdy", 32'(in_ready), 32'd0);
        in_data = 8'h22;
        cycle();
        check("bp_hold20", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        cycle();
        check("bp_show21", 32'(out_data), 32'h21);
        cycle();
        check("bp_show22", 32'(out_data), 32'h22);
        in_valid = 1'b0;
        cycle();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush while full drops both entries and the offered 0x33.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h30;
        cycle();
        in_data = 8'h31;
        cycle();
        flush   = 1'b1;
        in_data = 8'h33;
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rdy", 32'(in_ready), 32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) cycle();

        // Drain a single word and look at the idle data value.
        in_valid = 1'b1;
        in_data  = 8'h5A;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data", 32'(out_data), ZeroEn ? 32'h00 : 32'h5A);

        // Random traffic with rare flushes.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            flush     = ($urandom_range(0, 127) == 0);
            cycle();
        end
        flush = 1'b0;

        // Reset mid-operation discards buffered words.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        repeat (2) cycle();
        nreset = 1'b0;
        cycle();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", 32'(out_data), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
